// File: rtl/alu_seq.sv
// alu_seq: sequential ALU; single-cycle logic ops and WIDTH-cycle shift-add MUL / restoring DIV.
// Define ALU_DIV_EN to build the divider; otherwise opcode 011 completes in one cycle with ovf=1.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3+2*WIDTH:0] iw,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_out,
  output logic               ovf,
  output logic               dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [2:0]       iw_op;
  logic             iw_dt;
  logic [WIDTH-1:0] iw_a;
  logic [WIDTH-1:0] iw_b;
  logic             accept;
  logic             iter_op;

  logic [2:0]       op_p0;
  logic             sgn_p0;
  logic             neg_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  logic [2*WIDTH-1:0] prod_p1;
  logic [2*WIDTH-1:0] mcand_p1;
  logic [WIDTH-1:0]   mplier_p1;
  logic [2*WIDTH-1:0] mul_full;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             lt;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             res_dz;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  // A 2*WIDTH signed product fits in WIDTH bits when its top WIDTH+1 bits are all equal.
  function automatic logic fits_signed(input logic [2*WIDTH-1:0] p);
    return (&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]);
  endfunction

  assign iw_op    = iw[3+2*WIDTH -: 3];
  assign iw_dt    = iw[2*WIDTH];
  assign iw_a     = iw[2*WIDTH-1 -: WIDTH];
  assign iw_b     = iw[WIDTH-1:0];
  assign in_ready = (state == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] rem_p1;
  logic [WIDTH-1:0] quo_p1;
  logic [WIDTH-1:0] dvsr_p1;
  logic [WIDTH:0]   div_trial;

  assign iter_op   = (iw_op == OP_MUL) || (iw_op == OP_DIV);
  assign div_trial = {rem_p1, quo_p1[WIDTH-1]} - {1'b0, dvsr_p1};
`else
  assign iter_op   = (iw_op == OP_MUL);
`endif

  // p0: operands latched on accept; p1: iterative MUL/DIV state advanced while BUSY
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0     <= iw_op;
      sgn_p0    <= !iw_dt;
      neg_p0    <= !iw_dt && (iw_a[WIDTH-1] ^ iw_b[WIDTH-1]);
      a_p0      <= iw_a;
      b_p0      <= iw_b;
      prod_p1   <= '0;
      mcand_p1  <= {{WIDTH{1'b0}}, mag(iw_a, !iw_dt)};
      mplier_p1 <= mag(iw_b, !iw_dt);
`ifdef ALU_DIV_EN
      rem_p1    <= '0;
      quo_p1    <= mag(iw_a, !iw_dt);
      dvsr_p1   <= mag(iw_b, !iw_dt);
`endif
    end else if (state == S_BUSY) begin
      if (mplier_p1[0]) prod_p1 <= prod_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
`ifdef ALU_DIV_EN
      if (!div_trial[WIDTH]) begin
        rem_p1 <= div_trial[WIDTH-1:0];
        quo_p1 <= {quo_p1[WIDTH-2:0], 1'b1};
      end else begin
        rem_p1 <= {rem_p1[WIDTH-2:0], quo_p1[WIDTH-1]};
        quo_p1 <= {quo_p1[WIDTH-2:0], 1'b0};
      end
`endif
    end
  end

  // p2: result and flag selection from latched operands and finished iterations
  assign sum      = {1'b0, a_p0} + {1'b0, b_p0};
  assign dif      = {1'b0, a_p0} - {1'b0, b_p0};
  assign mul_full = neg_p0 ? -prod_p1 : prod_p1;
  assign lt       = sgn_p0 ? ($signed(a_p0) < $signed(b_p0)) : (a_p0 < b_p0);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    res_dz  = 1'b0;
    case (op_p0)
      OP_ADD: begin
        res     = sum[WIDTH-1:0];
        res_ovf = sgn_p0 ? ((a_p0[WIDTH-1] == b_p0[WIDTH-1]) && (sum[WIDTH-1] != a_p0[WIDTH-1]))
                         : sum[WIDTH];
      end
      OP_SUB: begin
        res     = dif[WIDTH-1:0];
        res_ovf = sgn_p0 ? ((a_p0[WIDTH-1] != b_p0[WIDTH-1]) && (dif[WIDTH-1] != a_p0[WIDTH-1]))
                         : dif[WIDTH];
      end
      OP_MUL: begin
        res     = mul_full[WIDTH-1:0];
        res_ovf = sgn_p0 ? !fits_signed(mul_full) : (|prod_p1[2*WIDTH-1:WIDTH]);
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (b_p0 == '0) begin
          res    = '1;
          res_dz = 1'b1;
        end else if (sgn_p0 && (a_p0 == MIN) && (b_p0 == '1)) begin
          res     = MIN;
          res_ovf = 1'b1;
        end else begin
          res = neg_p0 ? -quo_p1 : quo_p1;
        end
      end
`else
      OP_DIV: res_ovf = 1'b1;
`endif
      OP_AND: res = a_p0 & b_p0;
      OP_OR:  res = a_p0 | b_p0;
      OP_XOR: res = a_p0 ^ b_p0;
      OP_SLT: res = {{(WIDTH-1){1'b0}}, lt};
      default: res = '0;
    endcase
  end

  // Control FSM with registered result outputs; DONE spends one cycle loading the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= iter_op ? S_BUSY : S_DONE;
            cnt   <= '0;
          end
        end
        S_BUSY: begin
          if (cnt == LAST) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            alu_out   <= res;
            ovf       <= res_ovf;
            dz        <= res_dz;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (WIDTH=32), honours ALU_DIV_EN when defined.
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic S = 1'b0;
  localparam logic U = 1'b1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3+2*W:0] iw;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   alu_out;
  logic           ovf;
  logic           dz;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .iw(iw),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string what, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Issue one instruction, then wait for, score and pop its result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic dt,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic eo, input logic ed,
                        input int exp_lat, input int hold);
    int n;
    int lat;
    exp_t e;
    logic [W-1:0] held;
    @(negedge clk);
    iw = {op, dt, a, b};
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, "in_ready", in_ready, 1);
    sb.push_back('{res: er, ovf: eo, dz: ed});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    iw = {$urandom, $urandom, $urandom};
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 100);
    check(tag, "latency", lat, exp_lat);
    if (sb.size() == 0) begin
      check(tag, "sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check(tag, "alu_out", alu_out, e.res);
      check(tag, "ovf", ovf, e.ovf);
      check(tag, "dz", dz, e.dz);
    end
    held = alu_out;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      iw = {OP_ADD, U, 32'd1, 32'd1};
      @(negedge clk);
      check(tag, "hold_valid", out_valid, 1);
      check(tag, "hold_out", alu_out, held);
      check(tag, "hold_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check(tag, "pop_valid", out_valid, 0);
    check(tag, "pop_ready", in_ready, 1);
  endtask

  initial begin
    int lat_div;
    logic saw;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    iw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", "in_ready", in_ready, 0);
    check("reset", "out_valid", out_valid, 0);
    check("reset", "alu_out", alu_out, 0);
    check("reset", "ovf", ovf, 0);
    check("reset", "dz", dz, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_op("mul_s_1x2",  OP_MUL, S, 32'd1,        32'd2,        32'd2,        1'b0, 1'b0, 33, 0);
    run_op("mul_s_neg",  OP_MUL, S, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0, 1'b0, 33, 0);
    run_op("mul_u_ovf",  OP_MUL, U, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 33, 0);
    run_op("mul_s_ovf",  OP_MUL, S, 32'h00010000, 32'h00008000, 32'h80000000, 1'b1, 1'b0, 33, 0);
`ifdef ALU_DIV_EN
    lat_div = 33;
    run_op("div_u_4_4",  OP_DIV, U, 32'd4,        32'd4,        32'd1,        1'b0, 1'b0, lat_div, 0);
    run_op("div_s_m7_2", OP_DIV, S, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, lat_div, 0);
    run_op("div_s_7_m2", OP_DIV, S, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, lat_div, 0);
    run_op("div_by_0",   OP_DIV, U, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, lat_div, 0);
    run_op("div_min_m1", OP_DIV, S, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, lat_div, 0);
`else
    lat_div = 1;
    run_op("div_off",    OP_DIV, U, 32'd4,        32'd4,        32'd0,        1'b1, 1'b0, lat_div, 0);
    run_op("div_off_b0", OP_DIV, S, 32'd5,        32'd0,        32'd0,        1'b1, 1'b0, lat_div, 0);
`endif
    run_op("add_s_ovf",  OP_ADD, S, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1, 1'b0, 1, 0);
    run_op("add_u_cy",   OP_ADD, U, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b1, 1'b0, 1, 0);
    run_op("add_s_ok",   OP_ADD, S, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1'b0, 1, 0);
    run_op("sub_u_brw",  OP_SUB, U, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b1, 1'b0, 1, 0);
    run_op("sub_s_ovf",  OP_SUB, S, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b0, 1, 0);
    run_op("slt_s",      OP_SLT, S, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 1'b0, 1, 0);
    run_op("slt_u",      OP_SLT, U, 32'hFFFFFFFF, 32'd0,        32'd0,        1'b0, 1'b0, 1, 0);
    run_op("and",        OP_AND, S, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1, 0);
    run_op("or",         OP_OR,  U, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1, 0);
    run_op("xor_bp",     OP_XOR, S, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1, 5);

    // Reset during a multiply: the result must never appear.
    @(negedge clk);
    iw = {OP_MUL, S, 32'd1234, 32'd5678};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    saw = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1 saw = saw | out_valid;
    end
    check("rst_mul", "busy_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mul", "ready_in_rst", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mul", "ready_after", in_ready, 1);
    repeat (40) begin
      @(negedge clk);
      saw = saw | out_valid;
    end
    check("rst_mul", "no_valid", saw, 0);
    run_op("add_3_4",    OP_ADD, S, 32'd3,        32'd4,        32'd7,        1'b0, 1'b0, 1, 0);

    check("end", "sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
